// File: rtl/alu_wb_queue.sv
// alu_wb_queue: captures ALU results (with W-op sign extension) into a FIFO,
// drains them to the register-file write port and answers forwarding lookups.
module alu_wb_queue #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DEPTH          = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_res_valid,
    output logic                      o_res_ready,
    input  logic [BUS_DATA_WIDTH-1:0] i_res_data,
    input  logic [4:0]                i_res_rd,
    input  logic                      i_res_word,
    output logic                      o_wb_valid,
    input  logic                      i_wb_ready,
    output logic [4:0]                o_wb_rd,
    output logic [BUS_DATA_WIDTH-1:0] o_wb_data,
    input  logic [4:0]                i_fwd_rs,
    output logic                      o_fwd_hit,
    output logic [BUS_DATA_WIDTH-1:0] o_fwd_data,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [BUS_DATA_WIDTH-1:0] r_data [DEPTH];
    logic [4:0]                r_rd   [DEPTH];
    logic [AW-1:0]             r_wptr;
    logic [AW-1:0]             r_rptr;
    logic [AW:0]               r_count;
    logic                      w_enq;
    logic                      w_store;
    logic                      w_deq;
    logic [BUS_DATA_WIDTH-1:0] w_ext;
    // ready comes only from registered occupancy, never from wb_ready
    assign o_res_ready = r_count != (AW+1)'(DEPTH);
    assign o_wb_valid  = r_count != '0;
    assign w_enq       = i_res_valid & o_res_ready;
    assign w_store     = w_enq & (i_res_rd != 5'd0);
    assign w_deq       = o_wb_valid & i_wb_ready;
    assign w_ext       = i_res_word ? {{(BUS_DATA_WIDTH-32){i_res_data[31]}}, i_res_data[31:0]} : i_res_data;
    assign o_wb_rd     = o_wb_valid ? r_rd[r_rptr] : '0;
    assign o_wb_data   = o_wb_valid ? r_data[r_rptr] : '0;
    assign o_count     = r_count;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_store) - (AW+1)'(w_deq);
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_store && !i_reset) begin
            r_data[r_wptr] <= w_ext;
            r_rd[r_wptr]   <= i_res_rd;
        end
    end
    // scan oldest to newest so the newest matching entry is the one left standing
    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < r_count && i_fwd_rs != 5'd0 && r_rd[r_rptr + AW'(k)] == i_fwd_rs) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = r_data[r_rptr + AW'(k)];
            end
        end
    end
endmodule

// File: tb/tb_alu_wb_queue.sv
// tb_alu_wb_queue: directed vector table plus scoreboarded sequences for
// backpressure, pointer wrap and mid-queue reset.
module tb_alu_wb_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [4:0]  res_rd;
    logic        res_word;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic [2:0]  count;
    int n_run  = 0;
    int n_fail = 0;
    logic [68:0] q[$];

    always #5 clk = ~clk;

    alu_wb_queue #(.BUS_DATA_WIDTH(64), .DEPTH(4)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_res_valid(res_valid), .o_res_ready(res_ready), .i_res_data(res_data),
        .i_res_rd(res_rd), .i_res_word(res_word),
        .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .i_fwd_rs(fwd_rs), .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data), .o_count(count)
    );

    typedef struct {
        logic v; logic [4:0] rd; logic [63:0] d; logic w; logic rdy; logic [4:0] fs;
        logic rr; logic wv; logic [4:0] wrd; logic [63:0] wd; logic hit; logic [63:0] fd; logic [2:0] cnt;
    } vec_t;
    vec_t tbl[19];

    function automatic vec_t mk(logic v, logic [4:0] rd, logic [63:0] d, logic w, logic rdy, logic [4:0] fs,
                                logic rr, logic wv, logic [4:0] wrd, logic [63:0] wd, logic hit,
                                logic [63:0] fd, logic [2:0] cnt);
        vec_t t;
        t.v = v; t.rd = rd; t.d = d; t.w = w; t.rdy = rdy; t.fs = fs;
        t.rr = rr; t.wv = wv; t.wrd = wrd; t.wd = wd; t.hit = hit; t.fd = fd; t.cnt = cnt;
        return t;
    endfunction

    function automatic logic [63:0] ext(logic [63:0] d, logic w);
        return w ? {{32{d[31]}}, d[31:0]} : d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // one cycle against the queue model: check pre-edge outputs, then update model
    task automatic step(input logic v, input logic [4:0] rd, input logic [63:0] d, input logic w, input logic rdy);
        logic acc;
        logic deq;
        res_valid = v; res_rd = rd; res_data = d; res_word = w; wb_ready = rdy; fwd_rs = 5'd0;
        #1;
        chk("sb_ready", 64'(res_ready), 64'(q.size() != 4));
        chk("sb_count", 64'(count), 64'(q.size()));
        chk("sb_wb_valid", 64'(wb_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("sb_wb_rd", 64'(wb_rd), 64'(q[0][68:64]));
            chk("sb_wb_data", wb_data, q[0][63:0]);
        end
        acc = v && q.size() != 4;
        deq = q.size() != 0 && rdy;
        if (deq) void'(q.pop_front());
        if (acc && rd != 5'd0) q.push_back({rd, ext(d, w)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 64'h1234, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0,  1, 1, 5, 64'h1234, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 3, 64'h8000_0001, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 4, 64'h8000_0001, 0, 0, 3,  1, 1, 3, 64'hFFFF_FFFF_8000_0001, 1, 64'hFFFF_FFFF_8000_0001, 1);
        tbl[6]  = mk(0, 0, 0, 0, 1, 4,  1, 1, 3, 64'hFFFF_FFFF_8000_0001, 1, 64'h8000_0001, 2);
        tbl[7]  = mk(0, 0, 0, 0, 1, 4,  1, 1, 4, 64'h8000_0001, 1, 64'h8000_0001, 1);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 64'hDEAD, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 7, 64'hAAAA, 0, 0, 7,  1, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 7, 64'hBBBB, 0, 0, 7,  1, 1, 7, 64'hAAAA, 1, 64'hAAAA, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 7,  1, 1, 7, 64'hAAAA, 1, 64'hBBBB, 2);
        tbl[14] = mk(0, 0, 0, 0, 0, 9,  1, 1, 7, 64'hAAAA, 0, 0, 2);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,  1, 1, 7, 64'hAAAA, 0, 0, 2);
        tbl[16] = mk(0, 0, 0, 0, 1, 7,  1, 1, 7, 64'hAAAA, 1, 64'hBBBB, 2);
        tbl[17] = mk(0, 0, 0, 0, 1, 7,  1, 1, 7, 64'hBBBB, 1, 64'hBBBB, 1);
        tbl[18] = mk(0, 0, 0, 0, 1, 7,  1, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; res_valid = 1'b0; res_data = '0; res_rd = '0; res_word = 1'b0;
        wb_ready = 1'b0; fwd_rs = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            res_valid = tbl[i].v; res_rd = tbl[i].rd; res_data = tbl[i].d;
            res_word = tbl[i].w; wb_ready = tbl[i].rdy; fwd_rs = tbl[i].fs;
            #1;
            chk($sformatf("v%0d_res_ready", i), 64'(res_ready), 64'(tbl[i].rr));
            chk($sformatf("v%0d_wb_valid", i), 64'(wb_valid), 64'(tbl[i].wv));
            chk($sformatf("v%0d_wb_rd", i), 64'(wb_rd), 64'(tbl[i].wrd));
            chk($sformatf("v%0d_wb_data", i), wb_data, tbl[i].wd);
            chk($sformatf("v%0d_fwd_hit", i), 64'(fwd_hit), 64'(tbl[i].hit));
            chk($sformatf("v%0d_fwd_data", i), fwd_data, tbl[i].fd);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            @(posedge clk);
            #1;
        end

        q.delete();
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 64'h100 + 64'(i), 1'b0, 1'b0);
        step(1'b1, 5'd5, 64'h105, 1'b0, 1'b0);
        step(1'b1, 5'd5, 64'h105, 1'b0, 1'b1);
        step(1'b1, 5'd5, 64'h105, 1'b0, 1'b1);
        repeat (5) step(1'b0, 5'd0, 64'h0, 1'b0, 1'b1);

        for (int i = 1; i <= 12; i++)
            step(1'b1, 5'((i * 3) % 8), {32'hCAFE_0000 + 32'(i), (i % 2 == 1 ? 32'h8000_0000 : 32'h0) | 32'(i)},
                 i % 4 == 1, i % 3 != 0);
        repeat (6) step(1'b0, 5'd0, 64'h0, 1'b0, 1'b1);

        for (int i = 11; i <= 13; i++) step(1'b1, 5'(i), 64'h200 + 64'(i), 1'b0, 1'b0);
        res_valid = 1'b0; wb_ready = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        repeat (3) step(1'b0, 5'd0, 64'h0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
